// File: rtl/mcycle_wb_merge_if.sv
// Bus bundle between the multi-cycle unit, the main writeback
// stage and the register-file write port of the merge stage.
interface mcycle_wb_merge_if #(
  parameter int width = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             MPushIn;
  logic [width-1:0] MResult;
  logic [3:0]       MWA3;
  logic             PipeRegWrite;
  logic [3:0]       PipeWA3;
  logic [width-1:0] PipeWD3;
  logic             RegWrite;
  logic [3:0]       WA3;
  logic [width-1:0] WD3;
  logic             WriteSrc;
  logic [CW-1:0]    Count;
  logic             Empty;
  logic             Full;
  logic [15:0]      PendingMask;
  logic             Overflow;

  modport master (
    output MPushIn, MResult, MWA3,
    output PipeRegWrite, PipeWA3, PipeWD3,
    input  RegWrite, WA3, WD3, WriteSrc,
    input  Count, Empty, Full,
    input  PendingMask, Overflow
  );

  modport slave (
    input  MPushIn, MResult, MWA3,
    input  PipeRegWrite, PipeWA3, PipeWD3,
    output RegWrite, WA3, WD3, WriteSrc,
    output Count, Empty, Full,
    output PendingMask, Overflow
  );
endinterface

// File: rtl/mcycle_wb_merge.sv
// Queues multi-cycle results and merges them into the single
// register-file write port whenever the main pipeline is idle.
module mcycle_wb_merge #(
  parameter int width = 32,
  parameter int DEPTH = 4
) (
  input logic CLK,
  input logic Reset,
  mcycle_wb_merge_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] ONE = 1;

  logic [AW:0]      rp, wp;
  logic [AW-1:0]    ri, wi;
  logic [CW-1:0]    count;
  logic             full, empty;
  logic             pop, push, drop;
  logic             push_live;
  logic [DEPTH-1:0] live;
  logic [3:0]       wa3_q  [DEPTH];
  logic [width-1:0] data_q [DEPTH];
  logic [15:0]      mask;

  // Pointers carry an extra wrap bit so full and empty differ.
  assign ri    = rp[AW-1:0];
  assign wi    = wp[AW-1:0];
  assign count = wp - rp;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign pop  = !bus.PipeRegWrite && !empty;
  assign push = bus.MPushIn && (!full || pop);
  assign drop = bus.MPushIn && full && !pop;

  // A same-cycle pipeline write to the same register is younger.
  assign push_live = !(bus.PipeRegWrite &&
                       (bus.MWA3 == bus.PipeWA3));

  assign bus.Count       = count;
  assign bus.Empty       = empty;
  assign bus.Full        = full;
  assign bus.PendingMask = mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) mask[wa3_q[i]] = 1'b1;
    end
  end

  // Later assignments win: kill, then pop clear, then push.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rp   <= '0;
      wp   <= '0;
      live <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wa3_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.PipeRegWrite &&
            (wa3_q[i] == bus.PipeWA3))
          live[i] <= 1'b0;
      end
      if (pop) begin
        live[ri] <= 1'b0;
        rp       <= rp + ONE;
      end
      if (push) begin
        live[wi]   <= push_live;
        wa3_q[wi]  <= bus.MWA3;
        data_q[wi] <= bus.MResult;
        wp         <= wp + ONE;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      bus.RegWrite <= 1'b0;
      bus.WA3      <= '0;
      bus.WD3      <= '0;
      bus.WriteSrc <= 1'b0;
      bus.Overflow <= 1'b0;
    end else begin
      if (drop) bus.Overflow <= 1'b1;
      if (bus.PipeRegWrite) begin
        bus.RegWrite <= 1'b1;
        bus.WA3      <= bus.PipeWA3;
        bus.WD3      <= bus.PipeWD3;
        bus.WriteSrc <= 1'b0;
      end else if (pop) begin
        bus.RegWrite <= live[ri];
        bus.WriteSrc <= live[ri];
        if (live[ri]) begin
          bus.WA3 <= wa3_q[ri];
          bus.WD3 <= data_q[ri];
        end
      end else begin
        bus.RegWrite <= 1'b0;
        bus.WriteSrc <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mcycle_wb_merge.sv
// Directed bench for mcycle_wb_merge: latency, priority,
// overflow, kill, pointer wrap and async reset.
module tb_mcycle_wb_merge;
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int errors = 0;

  mcycle_wb_merge_if #(.width(32), .DEPTH(4)) bus ();

  mcycle_wb_merge #(.width(32), .DEPTH(4)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rw"}, 32'(bus.RegWrite), 32'd0);
    chk({tag, "_cnt"}, 32'(bus.Count), 32'd0);
    chk({tag, "_empty"}, 32'(bus.Empty), 32'd1);
    chk({tag, "_full"}, 32'(bus.Full), 32'd0);
    chk({tag, "_mask"}, 32'(bus.PendingMask), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.Overflow), 32'd0);
    chk({tag, "_wa3"}, 32'(bus.WA3), 32'd0);
    chk({tag, "_wd3"}, bus.WD3, 32'd0);
    chk({tag, "_src"}, 32'(bus.WriteSrc), 32'd0);
  endtask

  logic [3:0] wa [5];

  initial begin
    wa[0] = 4'd1; wa[1] = 4'd2; wa[2] = 4'd4;
    wa[3] = 4'd6; wa[4] = 4'd8;
    bus.MPushIn = 1'b0;
    bus.MResult = '0;
    bus.MWA3 = '0;
    bus.PipeRegWrite = 1'b0;
    bus.PipeWA3 = '0;
    bus.PipeWD3 = '0;

    #3;
    chk_reset("rst");
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;

    // single push, two-cycle latency
    bus.MPushIn = 1'b1;
    bus.MWA3 = 4'd5;
    bus.MResult = 32'h0000_00C8;
    tick();
    bus.MPushIn = 1'b0;
    chk("p1_mask", 32'(bus.PendingMask), 32'h0020);
    chk("p1_rw", 32'(bus.RegWrite), 32'd0);
    chk("p1_cnt", 32'(bus.Count), 32'd1);
    tick();
    chk("p2_rw", 32'(bus.RegWrite), 32'd1);
    chk("p2_wa3", 32'(bus.WA3), 32'd5);
    chk("p2_wd3", bus.WD3, 32'h0000_00C8);
    chk("p2_src", 32'(bus.WriteSrc), 32'd1);
    chk("p2_mask", 32'(bus.PendingMask), 32'd0);
    chk("p2_empty", 32'(bus.Empty), 32'd1);
    tick();
    chk("p3_rw", 32'(bus.RegWrite), 32'd0);
    chk("p3_wa3_hold", 32'(bus.WA3), 32'd5);

    // pipeline busy for 6 cycles, 5 pushes
    bus.PipeRegWrite = 1'b1;
    bus.PipeWA3 = 4'd15;
    for (int k = 0; k < 6; k++) begin
      bus.MPushIn = (k < 5);
      bus.MWA3 = (k < 5) ? wa[k] : 4'd0;
      bus.MResult = 32'h100 + 32'(k);
      bus.PipeWD3 = 32'hA000 + 32'(k);
      tick();
      if (k == 0) begin
        chk("ov_rw", 32'(bus.RegWrite), 32'd1);
        chk("ov_wa3", 32'(bus.WA3), 32'd15);
        chk("ov_wd3", bus.WD3, 32'hA000);
        chk("ov_src", 32'(bus.WriteSrc), 32'd0);
      end
    end
    bus.MPushIn = 1'b0;
    bus.PipeRegWrite = 1'b0;
    chk("ov_cnt", 32'(bus.Count), 32'd4);
    chk("ov_full", 32'(bus.Full), 32'd1);
    chk("ov_flag", 32'(bus.Overflow), 32'd1);
    chk("ov_mask", 32'(bus.PendingMask), 32'h0056);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("dr_rw", 32'(bus.RegWrite), 32'd1);
      chk("dr_wa3", 32'(bus.WA3), 32'(wa[k]));
      chk("dr_wd3", bus.WD3, 32'h100 + 32'(k));
      chk("dr_src", 32'(bus.WriteSrc), 32'd1);
    end
    chk("dr_empty", 32'(bus.Empty), 32'd1);
    chk("ov_sticky", 32'(bus.Overflow), 32'd1);

    // async reset in the middle of a drain
    bus.MPushIn = 1'b1;
    bus.MWA3 = 4'd9;
    bus.MResult = 32'h900;
    tick();
    bus.MWA3 = 4'd10;
    bus.MResult = 32'hA00;
    tick();
    bus.MPushIn = 1'b0;
    chk("mr_rw", 32'(bus.RegWrite), 32'd1);
    chk("mr_cnt", 32'(bus.Count), 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk_reset("arst");
    #1 Reset = 1'b0;

    // queued entry killed by a younger pipe write
    bus.MPushIn = 1'b1;
    bus.MWA3 = 4'd3;
    bus.MResult = 32'h33;
    tick();
    bus.MPushIn = 1'b0;
    chk("k_mask", 32'(bus.PendingMask), 32'h0008);
    bus.PipeRegWrite = 1'b1;
    bus.PipeWA3 = 4'd3;
    bus.PipeWD3 = 32'h77;
    tick();
    bus.PipeRegWrite = 1'b0;
    chk("k_rw", 32'(bus.RegWrite), 32'd1);
    chk("k_wa3", 32'(bus.WA3), 32'd3);
    chk("k_wd3", bus.WD3, 32'h77);
    chk("k_src", 32'(bus.WriteSrc), 32'd0);
    chk("k_mask2", 32'(bus.PendingMask), 32'd0);
    chk("k_cnt", 32'(bus.Count), 32'd1);
    tick();
    chk("k_pop_rw", 32'(bus.RegWrite), 32'd0);
    chk("k_pop_src", 32'(bus.WriteSrc), 32'd0);
    chk("k_pop_cnt", 32'(bus.Count), 32'd0);
    chk("k_pop_wd3", bus.WD3, 32'h77);

    // fill, then push+pop at Full for 10 cycles
    bus.PipeRegWrite = 1'b1;
    bus.PipeWA3 = 4'd15;
    bus.PipeWD3 = 32'h0;
    bus.MPushIn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      bus.MWA3 = 4'(n + 1);
      bus.MResult = 32'hD00 + 32'(n);
      tick();
    end
    bus.PipeRegWrite = 1'b0;
    chk("w_full", 32'(bus.Full), 32'd1);
    for (int n = 4; n < 14; n++) begin
      bus.MWA3 = 4'(n + 1);
      bus.MResult = 32'hD00 + 32'(n);
      tick();
      chk("w_rw", 32'(bus.RegWrite), 32'd1);
      chk("w_wa3", 32'(bus.WA3), 32'(n - 3));
      chk("w_wd3", bus.WD3, 32'hD00 + 32'(n - 4));
      chk("w_cnt", 32'(bus.Count), 32'd4);
    end
    bus.MPushIn = 1'b0;
    chk("w_ovf", 32'(bus.Overflow), 32'd0);
    chk("w_mask", 32'(bus.PendingMask), 32'h7800);
    for (int n = 10; n < 14; n++) begin
      tick();
      chk("wd_wa3", 32'(bus.WA3), 32'(n + 1));
      chk("wd_wd3", bus.WD3, 32'hD00 + 32'(n));
      chk("wd_src", 32'(bus.WriteSrc), 32'd1);
    end
    chk("wd_empty", 32'(bus.Empty), 32'd1);

    // same-cycle push and pipe write to one register
    bus.MPushIn = 1'b1;
    bus.MWA3 = 4'd7;
    bus.MResult = 32'h70;
    bus.PipeRegWrite = 1'b1;
    bus.PipeWA3 = 4'd7;
    bus.PipeWD3 = 32'h700;
    tick();
    bus.MPushIn = 1'b0;
    bus.PipeRegWrite = 1'b0;
    chk("s_rw", 32'(bus.RegWrite), 32'd1);
    chk("s_wa3", 32'(bus.WA3), 32'd7);
    chk("s_wd3", bus.WD3, 32'h700);
    chk("s_cnt", 32'(bus.Count), 32'd1);
    chk("s_mask", 32'(bus.PendingMask), 32'd0);
    tick();
    chk("s_pop_rw", 32'(bus.RegWrite), 32'd0);
    chk("s_pop_cnt", 32'(bus.Count), 32'd0);
    chk("s_pop_wd3", bus.WD3, 32'h700);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/mcycle_wb_merge.md
# mcycle_wb_merge

Writeback merge stage downstream of the multi-cycle multiply/divide unit. It buffers completed multiply/divide results (push strobe, result, destination register) in a small FIFO. It drains them into the single register-file write port whenever the main pipeline's writeback stage is not writing. It also exports a pending-destination mask for the hazard unit, and drops queued results that a younger pipeline write has already overwritten.

## Interface
Parameters:
- width, 32, data width of results and register-file write data
- DEPTH, 4, FIFO entries; power of two, ≥ 2

Ports:
- CLK  in  1  clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clock CLK
- MPushIn  in  1  one-cycle push strobe from the multi-cycle unit (its Done, registered)
- MResult  in  width  result accompanying MPushIn
- MWA3  in  4  destination register accompanying MPushIn
- PipeRegWrite  in  1  main pipeline writeback stage writes this cycle
- PipeWA3  in  4  main pipeline destination register
- PipeWD3  in  width  main pipeline write data
- RegWrite  out  1  registered register-file write enable
- WA3  out  4  registered register-file write address
- WD3  out  width  registered register-file write data
- WriteSrc  out  1  registered; 1 = current write came from the queue, 0 = from the pipeline
- Count  out  $clog2(DEPTH)+1  occupied entries (valid or killed)
- Empty  out  1  Count == 0
- Full  out  1  Count == DEPTH
- PendingMask  out  16  bit r set iff a live (non-killed) entry targets register r
- Overflow  out  1  sticky; set when a push is dropped

## Operation
- Storage: circular buffer of DEPTH entries {live, wa3[3:0], data[width-1:0]}, read pointer rp, write pointer wp, both $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Push: MPushIn=1 and (not Full, or a pop occurs in the same cycle) → write the entry at wp with live=1, then increment wp.
- Dropped push: MPushIn=1 while Full and no pop → entry discarded, Overflow←1, sticky until Reset.
- Pop condition: PipeRegWrite=0 and Count>0. The head entry is removed and rp increments.
  - Head live → RegWrite←1, WA3←head.wa3, WD3←head.data, WriteSrc←1.
  - Head killed → RegWrite←0, WriteSrc←0. The pop still consumes the cycle.
- Pipeline priority: PipeRegWrite=1 → RegWrite←1, WA3←PipeWA3, WD3←PipeWD3, WriteSrc←0. No pop occurs that cycle.
- Idle: neither a pipeline write nor a pop → RegWrite←0. WA3/WD3 hold their previous values.
- Kill (WAW): PipeRegWrite=1 → every stored entry with wa3==PipeWA3 gets live←0. A push in the same cycle with MWA3==PipeWA3 is also stored with live=0. The pipeline write is younger in program order and must win.
- PendingMask: combinational OR-decode of the wa3 of all live entries.
- Count/Empty/Full: combinational from the pointers plus a wrap bit.
- Hazards arising while a result is still inside the multi-cycle unit are not handled here; the hazard unit uses Busy/MCycleWA3 for those.

## Timing
- Reset (asynchronous): rp=wp=0, Count=0, Empty=1, Full=0, all live=0, PendingMask=0, Overflow=0, RegWrite=0, WA3=0, WD3=0, WriteSrc=0. Any in-flight entries are discarded.
- Push-to-write latency with the pipeline idle:
  - MPushIn at cycle N → entry stored at edge N+1.
  - Popped at edge N+2 → RegWrite=1 visible during cycle N+2.
  - There is no bypass from MPushIn to RegWrite.
- A pipeline write at cycle N appears on RegWrite/WA3/WD3 during cycle N+1.
- Simultaneous push and pop: Count unchanged.
  - At Full, the push is accepted because the pop frees a slot.
  - At Empty, no pop occurs (the push is not yet stored).
- Drain rate: one entry per cycle while PipeRegWrite=0.
- A continuous PipeRegWrite=1 starves the queue indefinitely; this is acceptable by design.
- Pointer wrap: the entry after index DEPTH-1 is index 0. Full and Empty are distinguished by the wrap bit.

## Test plan
- Reset with RegWrite/Count forced nonzero mid-drain → all outputs at reset values immediately (asynchronous), Empty=1.
- Single push MWA3=5, MResult=0x0000_00C8 at cycle 0, PipeRegWrite=0 → RegWrite=1, WA3=5, WD3=0xC8, WriteSrc=1 in cycle 2. PendingMask bit 5 is set in cycle 1 and clear in cycle 2.
- PipeRegWrite=1 held for 6 cycles while 5 pushes arrive (DEPTH=4) → fifth push dropped, Overflow=1, Full=1. The 4 entries then drain in order over 4 idle cycles.
- Push MWA3=3 queued, then pipeline writes WA3=3 → entry killed and PendingMask bit 3 clears. On the next idle cycle a pop occurs with RegWrite=0, and Count drops to 0.
- Queue Full with PipeRegWrite=0 and MPushIn=1 → push accepted, Count stays 4, no Overflow. Run 10 such cycles to exercise pointer wrap; output order must match push order.
- Same-cycle push MWA3=7 and PipeRegWrite=1 with PipeWA3=7 → pipeline write appears next cycle. The queued entry pops later with RegWrite=0.
